// File: rtl/clock_pkg.sv
// Shared types and limits for the wall-clock timekeeping controller.
package clock_pkg;

  localparam int unsigned TIME_W = 6;

  localparam logic [TIME_W-1:0] SEC_LAST = 6'd59;
  localparam logic [TIME_W-1:0] MIN_LAST = 6'd59;
  localparam logic [TIME_W-1:0] HRS_LAST = 6'd23;

  // Encoding chosen so the state register doubles as the field_sel output.
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HRS = 2'b01,
    SET_MIN = 2'b10
  } clk_mode_t;

  function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] last);
    return (v == last) ? '0 : v + TIME_W'(1);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for an already-debounced button level.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic prev_q;

  // History resets high so a button held through reset release gives no edge.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= btn;
  end

  assign rise = btn & ~prev_q;

endmodule

// File: rtl/clock_ctrl.sv
// Wall-clock timekeeping: 1 Hz prescaler, sec/min/hrs counters and a
// RUN -> SET_HRS -> SET_MIN set-mode FSM driven by two buttons.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter bit          BLINK_EN = 1'b1
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic              mode_btn,
  input  logic              inc_btn,
  output logic [TIME_W-1:0] sec,
  output logic [TIME_W-1:0] min,
  output logic [TIME_W-1:0] hrs,
  output logic              set_active,
  output logic [1:0]        field_sel,
  output logic              blink,
  output logic              sec_pulse
);

  localparam int unsigned    CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2 - 1);

  logic mode_edge, inc_edge, tick;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TIME_W-1:0] sec_q, sec_d, min_q, min_d, hrs_q, hrs_d;
  clk_mode_t         state_q, state_d;
  logic              blink_q, blink_d, pulse_q, pulse_d, set_active_q;

  btn_edge u_mode_edge (
    .clk   (clk_50MHz),
    .reset (reset),
    .btn   (mode_btn),
    .rise  (mode_edge)
  );

  btn_edge u_inc_edge (
    .clk   (clk_50MHz),
    .reset (reset),
    .btn   (inc_btn),
    .rise  (inc_edge)
  );

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    sec_d   = sec_q;
    min_d   = min_q;
    hrs_d   = hrs_q;
    state_d = state_q;
    blink_d = blink_q;
    pulse_d = 1'b0;

    case (state_q)
      RUN: begin
        blink_d = 1'b1;
        if (tick) begin
          pulse_d = 1'b1;
          sec_d   = wrap_inc(sec_q, SEC_LAST);
          if (sec_q == SEC_LAST) begin
            min_d = wrap_inc(min_q, MIN_LAST);
            if (min_q == MIN_LAST) hrs_d = wrap_inc(hrs_q, HRS_LAST);
          end
        end
        if (mode_edge) state_d = SET_HRS;
      end
      SET_HRS: begin
        if (mode_edge)     state_d = SET_MIN;
        else if (inc_edge) hrs_d   = wrap_inc(hrs_q, HRS_LAST);
      end
      SET_MIN: begin
        // Leaving set mode restarts the second from zero.
        if (mode_edge) begin
          state_d = RUN;
          sec_d   = '0;
          cnt_d   = '0;
        end else if (inc_edge) begin
          min_d = wrap_inc(min_q, MIN_LAST);
        end
      end
      default: state_d = RUN;
    endcase

    if (state_q != RUN && (cnt_q == CNT_HALF || tick)) blink_d = ~blink_q;
    if (mode_edge || !BLINK_EN) blink_d = 1'b1;
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      cnt_q        <= '0;
      sec_q        <= '0;
      min_q        <= '0;
      hrs_q        <= '0;
      state_q      <= RUN;
      blink_q      <= 1'b1;
      pulse_q      <= 1'b0;
      set_active_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sec_q        <= sec_d;
      min_q        <= min_d;
      hrs_q        <= hrs_d;
      state_q      <= state_d;
      blink_q      <= blink_d;
      pulse_q      <= pulse_d;
      set_active_q <= (state_d != RUN);
    end
  end

  assign sec        = sec_q;
  assign min        = min_q;
  assign hrs        = hrs_q;
  assign set_active = set_active_q;
  assign field_sel  = state_q;
  assign blink      = blink_q;
  assign sec_pulse  = pulse_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: directed scenarios plus random button traffic, every
// cycle checked against a time-of-day reference model.
module tb_clock_ctrl;

  localparam int TD = 4;

  logic       clk_50MHz = 1'b0;
  logic       reset = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [5:0] sec, min, hrs;
  logic       set_active;
  logic [1:0] field_sel;
  logic       blink, sec_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  // Reference model: mode 0=run, 1=set hours, 2=set minutes.
  int m_sec, m_min, m_hrs, m_mode, m_phase;
  bit m_blink, m_pulse, m_mprev, m_iprev;

  always #5 clk_50MHz = ~clk_50MHz;

  clock_ctrl #(
    .TICK_DIV (TD),
    .BLINK_EN (1'b1)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .reset      (reset),
    .mode_btn   (mode_btn),
    .inc_btn    (inc_btn),
    .sec        (sec),
    .min        (min),
    .hrs        (hrs),
    .set_active (set_active),
    .field_sel  (field_sel),
    .blink      (blink),
    .sec_pulse  (sec_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit md, input bit ic, input bit rs);
    bit me, ie, tk;
    int total, next_phase;
    if (rs) begin
      m_sec = 0; m_min = 0; m_hrs = 0; m_mode = 0; m_phase = 0;
      m_blink = 1; m_pulse = 0; m_mprev = 1; m_iprev = 1;
      return;
    end
    me = md && !m_mprev;
    ie = ic && !m_iprev;
    m_mprev = md;
    m_iprev = ic;
    tk = (m_phase == TD - 1);
    next_phase = (m_phase + 1) % TD;
    m_pulse = (m_mode == 0) && tk;
    if (m_mode == 0) begin
      m_blink = 1;
      if (tk) begin
        total = (m_hrs * 3600 + m_min * 60 + m_sec + 1) % 86400;
        m_hrs = total / 3600;
        m_min = (total / 60) % 60;
        m_sec = total % 60;
      end
    end else if (!me) begin
      if (ie && m_mode == 1) m_hrs = (m_hrs + 1) % 24;
      if (ie && m_mode == 2) m_min = (m_min + 1) % 60;
      if ((m_phase + 1) % (TD / 2) == 0) m_blink = !m_blink;
    end
    if (me) begin
      if (m_mode == 2) begin
        m_sec = 0;
        next_phase = 0;
      end
      m_mode  = (m_mode + 1) % 3;
      m_blink = 1;
    end
    m_phase = next_phase;
  endtask

  task automatic check_all();
    chk("sec", sec, m_sec);
    chk("min", min, m_min);
    chk("hrs", hrs, m_hrs);
    chk("field_sel", field_sel, m_mode);
    chk("set_active", set_active, (m_mode != 0));
    chk("blink", blink, m_blink);
    chk("sec_pulse", sec_pulse, m_pulse);
  endtask

  task automatic cycle(input bit md, input bit ic, input bit rs);
    mode_btn = md;
    inc_btn  = ic;
    reset    = rs;
    model_step(md, ic, rs);
    @(posedge clk_50MHz);
    #1;
    check_all();
    if (sec_pulse) pulses++;
  endtask

  task automatic press_mode();
    cycle(1, 0, 0);
    cycle(0, 0, 0);
  endtask

  task automatic press_inc();
    cycle(0, 1, 0);
    cycle(0, 0, 0);
  endtask

  initial begin
    int  prev_sec;
    bit  seen_roll;
    logic [5:0] sec_hold;

    // Reset state
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk("rst_sec", sec, 0);
    chk("rst_min", min, 0);
    chk("rst_hrs", hrs, 0);
    chk("rst_field", field_sel, 0);
    chk("rst_blink", blink, 1);
    chk("rst_pulse", sec_pulse, 0);

    // One minute of run time
    pulses = 0;
    repeat (60 * TD) begin
      cycle(0, 0, 0);
      chk("sec_range", (sec < 60), 1);
    end
    chk("pulse_count", pulses, 60);
    chk("min_after_60s", min, 1);
    chk("sec_after_60s", sec, 0);

    // Set 23:59 by buttons, then run through midnight
    press_mode();
    repeat (23) press_inc();
    press_mode();
    repeat (58) press_inc();
    chk("set_hrs23", hrs, 23);
    chk("set_min59", min, 59);
    press_mode();
    chk("exit_sec0", sec, 0);
    seen_roll = 0;
    prev_sec  = sec;
    repeat (60 * TD) begin
      cycle(0, 0, 0);
      chk("hrs_range", (hrs < 24), 1);
      if (prev_sec == 59 && sec != 59) begin
        seen_roll = 1;
        chk("midnight", {18'd0, hrs, min, sec}, 0);
      end
      prev_sec = sec;
    end
    chk("midnight_seen", seen_roll, 1);

    // Held mode button gives exactly one transition
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0);
      if (i == 0) chk("held_mode_first", field_sel, 1);
    end
    chk("held_mode_stay", field_sel, 1);
    cycle(0, 0, 0);

    // Minute wrap in SET_MIN does not carry into hours
    repeat (5) press_inc();
    press_mode();
    repeat (59) press_inc();
    chk("pre_min59", min, 59);
    sec_hold = sec;
    press_inc();
    chk("min_wrap", min, 0);
    chk("no_carry_hrs", hrs, 5);
    chk("sec_frozen", sec, sec_hold);

    // Simultaneous mode and inc edges: mode wins
    press_mode();
    press_mode();
    repeat (22) press_inc();
    chk("pre_hrs3", hrs, 3);
    cycle(1, 1, 0);
    chk("both_state", field_sel, 2);
    chk("both_hrs", hrs, 3);
    cycle(0, 0, 0);

    // Reset inside SET_MIN with inc held through release
    cycle(0, 1, 1);
    chk("mid_rst_field", field_sel, 0);
    chk("mid_rst_time", {18'd0, hrs, min, sec}, 0);
    chk("mid_rst_blink", blink, 1);
    repeat (3) cycle(0, 1, 0);
    chk("held_inc_min", min, 0);
    chk("held_inc_hrs", hrs, 0);
    cycle(0, 0, 0);

    // Random button traffic with occasional reset
    repeat (1500) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
